// File: rtl/feedback_loop_window_stats_pkg.sv
// Shared types for the feedback-loop window statistics block.
// Default sample/window geometry plus the window FSM state encoding.
package feedback_loop_types;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_LOG2_DEPTH = 3;

  typedef logic signed [DEF_WIDTH-1:0]                sample_t;
  typedef logic signed [DEF_WIDTH+DEF_LOG2_DEPTH-1:0] sum_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } win_state_t;

endpackage

// File: rtl/feedback_loop_window_stats_sample_ring.sv
// DEPTH x WIDTH sample ring with a wrapping write pointer.
// The entry under the write pointer is the oldest sample, about to be replaced.
module feedback_loop_sample_ring
  import feedback_loop_types::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOG2_DEPTH = DEF_LOG2_DEPTH
) (
  input  logic             system1000,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] oldest
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [WIDTH-1:0]      ring [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;

  always_ff @(posedge system1000) begin
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (wr_en) begin
      ring[wr_ptr] <= wr_data;
      wr_ptr       <= wr_ptr + 1'b1;
    end
  end

  assign oldest = ring[wr_ptr];

endmodule

// File: rtl/feedback_loop_window_stats.sv
// Sliding-window sum/mean over the feedback-loop sample stream, with a
// registered valid/ready result port and a sticky overrun flag.
//
// state | meaning
// ------+--------------------------------------------------------------
// FILL  | window not yet full; samples counted, no results produced
// RUN   | window full; every accepted sample produces a new result
module feedback_loop_window_stats
  import feedback_loop_types::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOG2_DEPTH = DEF_LOG2_DEPTH
) (
  input  logic                        system1000,
  input  logic                        system1000_rst,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [WIDTH+LOG2_DEPTH-1:0] out_sum,
  output logic [WIDTH-1:0]            out_mean,
  output logic                        out_overrun,
  output logic [LOG2_DEPTH:0]         fill_level
);

  localparam int SUM_W = WIDTH + LOG2_DEPTH;
  localparam int LVL_W = LOG2_DEPTH + 1;
  localparam int DEPTH = 1 << LOG2_DEPTH;

  win_state_t       state, state_nxt;
  logic             flush;
  logic             accept;
  logic             last_fill;
  logic             new_result;
  logic [WIDTH-1:0] ring_oldest;
  logic [WIDTH-1:0] oldest;
  logic [SUM_W-1:0] run_sum;
  logic [SUM_W-1:0] sum_nxt;

  // A flush in the same cycle as a sample discards the sample.
  assign flush     = system1000_rst | clear;
  assign accept    = in_valid & ~flush;
  assign last_fill = (fill_level == LVL_W'(DEPTH - 1));

  feedback_loop_sample_ring #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .system1000 (system1000),
    .flush      (flush),
    .wr_en      (accept),
    .wr_data    (in_data),
    .oldest     (ring_oldest)
  );

  assign oldest  = (state == RUN) ? ring_oldest : '0;
  assign sum_nxt = run_sum
                 + {{LOG2_DEPTH{in_data[WIDTH-1]}}, in_data}
                 - {{LOG2_DEPTH{oldest[WIDTH-1]}}, oldest};

  always_ff @(posedge system1000) begin
    if (flush) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    new_result = 1'b0;
    case (state)
      FILL: begin
        if (accept && last_fill) begin
          state_nxt  = RUN;
          new_result = 1'b1;
        end
      end
      RUN: begin
        new_result = accept;
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge system1000) begin
    if (flush) begin
      run_sum    <= '0;
      fill_level <= '0;
    end else if (accept) begin
      run_sum <= sum_nxt;
      if (state == FILL) begin
        fill_level <= fill_level + 1'b1;
      end
    end
  end

  // Mean is the sum's upper bits: an arithmetic shift, i.e. floor toward -inf.
  always_ff @(posedge system1000) begin
    if (flush) begin
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_mean    <= '0;
      out_overrun <= 1'b0;
    end else if (new_result) begin
      out_valid <= 1'b1;
      out_sum   <= sum_nxt;
      out_mean  <= sum_nxt[SUM_W-1:LOG2_DEPTH];
      if (out_valid && !out_ready) begin
        out_overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_feedback_loop_window_stats.sv
// Randomised and directed bench for feedback_loop_window_stats against a
// queue-based window model that recomputes sum and floor-mean from scratch.
module tb_feedback_loop_window_stats;

  logic        system1000 = 1'b0;
  logic        system1000_rst;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;
  logic        out_valid;
  logic [10:0] out_sum;
  logic [7:0]  out_mean;
  logic        out_overrun;
  logic [3:0]  fill_level;

  int checks = 0;
  int errors = 0;

  int q[$];
  bit m_valid;
  int m_sum;
  int m_mean;
  bit m_ovr;

  always #5 system1000 = ~system1000;

  feedback_loop_window_stats dut (
    .system1000     (system1000),
    .system1000_rst (system1000_rst),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_sum        (out_sum),
    .out_mean       (out_mean),
    .out_overrun    (out_overrun),
    .fill_level     (fill_level)
  );

  function automatic int floor8(input int s);
    int r;
    r = s % 8;
    return (s - ((r + 8) % 8)) / 8;
  endfunction

  function automatic logic [24:0] exp_vec();
    return {m_valid, 11'(m_sum), 8'(m_mean), m_ovr, 4'(q.size())};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {out_valid, out_sum, out_mean, out_overrun, fill_level};
  endfunction

  // Drive one cycle, advance the model at the edge, return at the falling edge.
  task automatic step(input logic r, input logic c, input logic iv, input int d,
                      input logic rdy);
    bit newres;
    int s;
    system1000_rst = r;
    clear          = c;
    in_valid       = iv;
    in_data        = d[7:0];
    out_ready      = rdy;
    @(posedge system1000);
    if (r || c) begin
      q.delete();
      m_valid = 0; m_sum = 0; m_mean = 0; m_ovr = 0;
    end else begin
      newres = 0;
      if (iv) begin
        q.push_back(d);
        if (q.size() > 8) void'(q.pop_front());
        if (q.size() == 8) newres = 1;
      end
      if (newres) begin
        if (m_valid && !rdy) m_ovr = 1;
        m_valid = 1;
        s = 0;
        foreach (q[i]) s += q[i];
        m_sum  = s;
        m_mean = floor8(s);
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end
    @(negedge system1000);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 5, 1);
      checks++;
      if ({out_valid, fill_level, out_overrun} !== 6'b0) begin
        errors++;
        $display("FAIL reset[%0d]: got valid=%0b fill=%0d ovr=%0b, want 0/0/0",
                 i, out_valid, fill_level, out_overrun);
      end
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 16, 1);
      checks++;
      if (out_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fill[%0d]: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    step(0, 0, 1, 16, 1);
    checks++;
    if ({out_valid, out_sum, out_mean, fill_level} !== {1'b1, 11'd128, 8'd16, 4'd8}) begin
      errors++;
      $display("FAIL fill_full: got valid=%0b sum=%0d mean=%0d fill=%0d, want 1/128/16/8",
               out_valid, $signed(out_sum), $signed(out_mean), fill_level);
    end
  endtask

  task automatic test_slide();
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, -3, 1);
      checks++;
      if (out_sum !== 11'(128 - 19 * (i + 1)) || out_valid !== 1'b1 ||
          dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL slide[%0d]: got sum=%0d valid=%0b, want sum=%0d valid=1",
                 i, $signed(out_sum), out_valid, 128 - 19 * (i + 1));
      end
    end
    checks++;
    if (out_sum !== 11'(-24) || out_mean !== 8'(-3) || out_overrun !== 1'b0) begin
      errors++;
      $display("FAIL slide_final: got sum=%0d mean=%0d ovr=%0b, want -24/-3/0",
               $signed(out_sum), $signed(out_mean), out_overrun);
    end
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 8; i++) step(0, 0, 1, -128, 1);
    checks++;
    if (out_sum !== 11'(-1024) || out_mean !== 8'(-128)) begin
      errors++;
      $display("FAIL ext_min: got sum=%0d mean=%0d, want -1024/-128",
               $signed(out_sum), $signed(out_mean));
    end
    for (int i = 0; i < 8; i++) step(0, 0, 1, 127, 1);
    checks++;
    if (out_sum !== 11'd1016 || out_mean !== 8'd127) begin
      errors++;
      $display("FAIL ext_max: got sum=%0d mean=%0d, want 1016/127",
               $signed(out_sum), $signed(out_mean));
    end
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 1);
    step(0, 0, 1, -1, 1);
    checks++;
    if (out_sum !== 11'(-1) || out_mean !== 8'(-1) || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL ext_neg1: got sum=%0d mean=%0d, want -1/-1",
               $signed(out_sum), $signed(out_mean));
    end
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 1);
    step(0, 0, 1, 7, 1);
    checks++;
    if (out_mean !== 8'd0 || out_sum !== 11'd7) begin
      errors++;
      $display("FAIL ext_pos7: got sum=%0d mean=%0d, want 7/0",
               $signed(out_sum), $signed(out_mean));
    end
  endtask

  task automatic test_backpressure();
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8, 1);
    step(0, 0, 1, 10, 0);
    step(0, 0, 1, 20, 0);
    checks++;
    if ({out_valid, out_overrun, out_sum} !== {1'b1, 1'b1, 11'd78}) begin
      errors++;
      $display("FAIL bp_overrun: got valid=%0b ovr=%0b sum=%0d, want 1/1/78",
               out_valid, out_overrun, $signed(out_sum));
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 11'd78 || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%0b sum=%0d, want 1/78",
                 i, out_valid, $signed(out_sum));
      end
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || out_overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: got valid=%0b ovr=%0b, want 0/1", out_valid, out_overrun);
    end
  endtask

  task automatic test_clear_midfill();
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 3, 1);
    checks++;
    if (fill_level !== 4'd5) begin
      errors++;
      $display("FAIL midfill_level: got %0d want 5", fill_level);
    end
    step(0, 1, 1, 9, 1);
    checks++;
    if (fill_level !== 4'd0 || out_overrun !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midfill_clear: got fill=%0d ovr=%0b valid=%0b, want 0/0/0",
               fill_level, out_overrun, out_valid);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 1);
    checks++;
    if (out_sum !== 11'd8 || out_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL midfill_refill: got sum=%0d valid=%0b, want 8/1",
               $signed(out_sum), out_valid);
    end
  endtask

  task automatic test_random();
    int d;
    logic c, r, iv, rdy;
    for (int i = 0; i < 400; i++) begin
      d   = int'($urandom_range(0, 255)) - 128;
      r   = ($urandom_range(0, 99) == 0);
      c   = ($urandom_range(0, 49) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      step(r, c, iv, d, rdy);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h (sum %0d/%0d)",
                 i, dut_vec(), exp_vec(), $signed(out_sum), m_sum);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_slide();
    test_extremes();
    test_backpressure();
    test_clear_midfill();
    step(1, 0, 0, 0, 1);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
